// File: rtl/alu_unit.sv
// Registered integer ALU; defining ALU_EXT_OPS_EN adds SLL/SRL/SLT on ops 101/110/111.
// Latency 1 cycle; no backpressure, one operation accepted per cycle.
module alu_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       op,
    output logic             out_valid,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             negative,
    output logic             carry,
    output logic             overflow
);

    typedef enum logic [2:0] {
        OP_ADD = 3'b000,
        OP_SUB = 3'b001,
        OP_AND = 3'b010,
        OP_OR  = 3'b011,
        OP_XOR = 3'b100,
        OP_SLL = 3'b101,
        OP_SRL = 3'b110,
        OP_SLT = 3'b111
    } alu_op_e;

`ifdef ALU_EXT_OPS_EN
    localparam int SHW = $clog2(WIDTH);
    logic [SHW-1:0]   shamt;
    logic             slt;
`endif

    alu_op_e          op_e;
    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   diff;
    logic             add_ovf;
    logic             sub_ovf;

    logic [WIDTH-1:0] result_d, result_q;
    logic             carry_d, carry_q;
    logic             overflow_d, overflow_q;
    logic             zero_d, zero_q;
    logic             negative_d, negative_q;
    logic             valid_q;

    assign op_e = alu_op_e'(op);

    // Extra top bit of the unsigned difference is set exactly when a < b (borrow).
    assign sum     = {1'b0, a} + {1'b0, b};
    assign diff    = {1'b0, a} - {1'b0, b};
    assign add_ovf = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1]  != a[WIDTH-1]);
    assign sub_ovf = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);

`ifdef ALU_EXT_OPS_EN
    assign shamt = b[SHW-1:0];
    assign slt   = $signed(a) < $signed(b);
`endif

    always_comb begin
        result_d   = '0;
        carry_d    = 1'b0;
        overflow_d = 1'b0;
        unique case (op_e)
            OP_ADD: begin
                result_d   = sum[WIDTH-1:0];
                carry_d    = sum[WIDTH];
                overflow_d = add_ovf;
            end
            OP_SUB: begin
                result_d   = diff[WIDTH-1:0];
                carry_d    = diff[WIDTH];
                overflow_d = sub_ovf;
            end
            OP_AND: result_d = a & b;
            OP_OR:  result_d = a | b;
            OP_XOR: result_d = a ^ b;
`ifdef ALU_EXT_OPS_EN
            OP_SLL: result_d = a << shamt;
            OP_SRL: result_d = a >> shamt;
            OP_SLT: result_d = {{(WIDTH-1){1'b0}}, slt};
`else
            OP_SLL, OP_SRL, OP_SLT: result_d = '0;
`endif
            default: result_d = '0;
        endcase
        zero_d     = (result_d == '0);
        negative_d = result_d[WIDTH-1];
    end

    // Result and flags hold across idle cycles; only out_valid tracks in_valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q    <= 1'b0;
            result_q   <= '0;
            carry_q    <= 1'b0;
            overflow_q <= 1'b0;
            zero_q     <= 1'b0;
            negative_q <= 1'b0;
        end else begin
            valid_q <= in_valid;
            if (in_valid) begin
                result_q   <= result_d;
                carry_q    <= carry_d;
                overflow_q <= overflow_d;
                zero_q     <= zero_d;
                negative_q <= negative_d;
            end
        end
    end

    assign out_valid = valid_q;
    assign result    = result_q;
    assign zero      = zero_q;
    assign negative  = negative_q;
    assign carry     = carry_q;
    assign overflow  = overflow_q;

endmodule

// File: tb/tb_alu_unit.sv
// Directed-vector bench for alu_unit with hand-computed expected results.
module tb_alu_unit;

    localparam int WIDTH = 32;

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [2:0]       op;
    logic             out_valid;
    logic [WIDTH-1:0] result;
    logic             zero;
    logic             negative;
    logic             carry;
    logic             overflow;

    int n_tests;
    int n_fail;

    alu_unit #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .a         (a),
        .b         (b),
        .op        (op),
        .out_valid (out_valid),
        .result    (result),
        .zero      (zero),
        .negative  (negative),
        .carry     (carry),
        .overflow  (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [WIDTH-1:0] got, input logic [WIDTH-1:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic v, input logic [WIDTH-1:0] res,
                           input logic z, input logic n, input logic c, input logic o);
        chk({tag, ".vld"}, {31'd0, out_valid}, {31'd0, v});
        chk({tag, ".res"}, result, res);
        chk({tag, ".z"},   {31'd0, zero},      {31'd0, z});
        chk({tag, ".n"},   {31'd0, negative},  {31'd0, n});
        chk({tag, ".c"},   {31'd0, carry},     {31'd0, c});
        chk({tag, ".o"},   {31'd0, overflow},  {31'd0, o});
    endtask

    // Drive on the falling edge, return 1ns after the capturing rising edge.
    task automatic step(input logic v, input logic [2:0] o, input logic [WIDTH-1:0] av,
                        input logic [WIDTH-1:0] bv);
        @(negedge clk);
        in_valid = v;
        op       = o;
        a        = av;
        b        = bv;
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_tests  = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        op       = 3'b000;
        a        = '0;
        b        = '0;
        #3;
        chk_all("reset", 1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        // Basic ops on 15, 10, back to back
        step(1'b1, 3'b000, 32'd15, 32'd10); chk_all("add15_10", 1'b1, 32'd25, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 3'b001, 32'd15, 32'd10); chk_all("sub15_10", 1'b1, 32'd5,  1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 3'b010, 32'd15, 32'd10); chk_all("and15_10", 1'b1, 32'd10, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 3'b011, 32'd15, 32'd10); chk_all("or15_10",  1'b1, 32'd15, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 3'b100, 32'd15, 32'd10); chk_all("xor15_10", 1'b1, 32'd5,  1'b0, 1'b0, 1'b0, 1'b0);

        // Arithmetic boundaries
        step(1'b1, 3'b000, 32'h7FFF_FFFF, 32'd1); chk_all("add_ovf",   1'b1, 32'h8000_0000, 1'b0, 1'b1, 1'b0, 1'b1);
        step(1'b1, 3'b000, 32'hFFFF_FFFF, 32'd1); chk_all("add_carry", 1'b1, 32'd0,         1'b1, 1'b0, 1'b1, 1'b0);
        step(1'b1, 3'b001, 32'd10, 32'd15);       chk_all("sub_borrow",1'b1, 32'hFFFF_FFFB, 1'b0, 1'b1, 1'b1, 1'b0);
        step(1'b1, 3'b001, 32'h8000_0000, 32'd1); chk_all("sub_ovf",   1'b1, 32'h7FFF_FFFF, 1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b1, 3'b100, 32'hA5A5_A5A5, 32'hA5A5_A5A5); chk_all("xor_zero", 1'b1, 32'd0, 1'b1, 1'b0, 1'b0, 1'b0);

        // Hold behaviour with in_valid low
        step(1'b1, 3'b000, 32'd15, 32'd10); chk_all("hold_add", 1'b1, 32'd25, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 3'b001, 32'd1, 32'd2);
            chk_all($sformatf("hold%0d", i), 1'b0, 32'd25, 1'b0, 1'b0, 1'b0, 1'b0);
        end

        // Asynchronous reset in the middle of a valid stream
        step(1'b1, 3'b000, 32'hFFFF_FFFF, 32'd1); chk_all("pre_rst", 1'b1, 32'd0, 1'b1, 1'b0, 1'b1, 1'b0);
        step(1'b1, 3'b001, 32'd10, 32'd15);
        #2;
        rst_n = 1'b0;
        #1;
        chk_all("async_rst", 1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        step(1'b0, 3'b000, 32'd1, 32'd2); chk_all("post_rst_idle", 1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 3'b000, 32'd1, 32'd2); chk_all("post_rst_add",  1'b1, 32'd3, 1'b0, 1'b0, 1'b0, 1'b0);

`ifdef ALU_EXT_OPS_EN
        step(1'b1, 3'b101, 32'd1, 32'd35);            chk_all("sll",      1'b1, 32'd8, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 3'b101, 32'h1234_5678, 32'd32);    chk_all("sll_zero", 1'b1, 32'h1234_5678, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 3'b110, 32'h8000_0000, 32'd31);    chk_all("srl",      1'b1, 32'd1, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 3'b111, 32'hFFFF_FFFF, 32'd0);     chk_all("slt_t",    1'b1, 32'd1, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 3'b111, 32'd0, 32'hFFFF_FFFF);     chk_all("slt_f",    1'b1, 32'd0, 1'b1, 1'b0, 1'b0, 1'b0);
`else
        step(1'b1, 3'b101, 32'd1, 32'd35);            chk_all("op101", 1'b1, 32'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 3'b000, 32'd15, 32'd10);           chk_all("re_add", 1'b1, 32'd25, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 3'b110, 32'h8000_0000, 32'd31);    chk_all("op110", 1'b1, 32'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 3'b000, 32'h7FFF_FFFF, 32'd1);     chk_all("re_ovf", 1'b1, 32'h8000_0000, 1'b0, 1'b1, 1'b0, 1'b1);
        step(1'b1, 3'b111, 32'hFFFF_FFFF, 32'd0);     chk_all("op111", 1'b1, 32'd0, 1'b1, 1'b0, 1'b0, 1'b0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_unit.md
Name: alu_unit

Overview:
- Registered integer ALU for the RISC-V core datapath.
- Performs one arithmetic or logic operation on two WIDTH-bit operands per accepted input.
- Result and status flags are registered with one-cycle latency.
- Sits between the register-file read stage and writeback.

Parameters:
- WIDTH, 32, operand and result width in bits; legal values are powers of two, minimum 8.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  qualifies a, b and op for this cycle.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- op  input  3  operation select.
- out_valid  output  1  result and flags are from the previous cycle's accepted input.
- result  output  WIDTH  registered operation result.
- zero  output  1  registered flag: result equals 0.
- negative  output  1  registered copy of result MSB.
- carry  output  1  registered carry out (ADD) or borrow (SUB).
- overflow  output  1  registered signed-overflow flag.

Behaviour:
- One clock; reset is asynchronous and active-low.
- Asserting rst_n low at any time, including mid-operation, immediately clears all outputs: out_valid=0, result=0, zero=0, negative=0, carry=0, overflow=0.
- First capture after reset release is on the first rising clk edge with rst_n high.
- Latency is 1 cycle. When in_valid=1 at a rising edge:
  - result and flags update with f(a, b, op) at that edge.
  - out_valid=1 for the following cycle.
- When in_valid=0 at a rising edge, out_valid goes to 0 and result and flags hold their last values. There is no backpressure.
- Back-to-back in_valid accepts one operation per cycle.
- Op encoding:
  - 000 ADD: a+b mod 2^WIDTH. carry = bit WIDTH of the unsigned sum. overflow = operand signs equal and result sign differs.
  - 001 SUB: a-b mod 2^WIDTH. carry = 1 when a<b unsigned (borrow). overflow = operand signs differ and result sign differs from a.
  - 010 AND: a & b.
  - 011 OR: a | b.
  - 100 XOR: a ^ b.
  - 101, 110, 111: extended ops, see Optional Feature.
- For all non-ADD/SUB ops, carry=0 and overflow=0.
- zero and negative are always derived from the registered result.
- Operands are treated as unsigned except for overflow detection and SLT.
- Arithmetic wraps silently; no saturation.

Optional Feature:
- Macro ALU_EXT_OPS_EN.
- Defined:
  - 101 SLL: a << b[log2(WIDTH)-1:0].
  - 110 SRL: logical right shift of a by b[log2(WIDTH)-1:0].
  - 111 SLT: result = 1 if a < b signed, else 0.
  - Upper bits of b are ignored for shifts; shift amount 0 returns a unchanged.
  - carry=0 and overflow=0 for all three ops.
- Not defined:
  - Ops 101, 110 and 111 produce result=0, flags zero=1, negative=0, carry=0, overflow=0.
  - out_valid behaves normally.

Test Plan:
- Reset then a=15, b=10, in_valid=1, op=000/001/010/011/100 on consecutive cycles -> result 25, 5, 10, 15, 5 one cycle after each. out_valid=1 throughout; zero=0 and carry=0 for all.
- ADD a=0x7FFFFFFF, b=1 -> result 0x80000000, overflow=1, negative=1, carry=0. ADD a=0xFFFFFFFF, b=1 -> result 0, zero=1, carry=1, overflow=0.
- SUB a=10, b=15 -> result 0xFFFFFFFB, carry=1, negative=1, overflow=0. SUB a=0x80000000, b=1 -> 0x7FFFFFFF, overflow=1.
- in_valid=1 with ADD 15+10, then in_valid=0 with op=001 for 3 cycles -> result stays 25, out_valid high one cycle then low.
- Assert rst_n low between clock edges during a valid stream -> all outputs 0 immediately without a clock edge; first output after release is 1 cycle after the next accepted input.
- With ALU_EXT_OPS_EN: SLL a=1, b=35 -> 8; SRL a=0x80000000, b=31 -> 1; SLT a=0xFFFFFFFF, b=0 -> 1. Without the macro, op=101 -> result 0, zero=1.
